key_click_classifier: RTL and testbench

Downstream consumer of the debouncer's one-cycle `key_pressed_stb_o` strobe.
- Groups press strobes that arrive within a configurable inactivity window into one click event: single, double, up to `MAX_CLICKS`.
- Buffers completed events in a small FIFO with a valid/ready handshake toward the control logic.
- Counts events lost to FIFO overflow.

---
 rtl/key_click_classifier.sv | 180 ++++++++++++++++++
 tb/tb_key_click_classifier.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_click_classifier.sv
// key_click_classifier: groups debounced key-press strobes into click events
// (single/double/... up to MAX_CLICKS) and buffers them in a valid/ready FIFO.
// Optional feature macro: KEY_CLICK_CLASSIFIER_DROP_CNT_EN adds drop_cnt_o, an
// 8-bit saturating count of events lost to FIFO overflow.
module key_click_classifier #(
  parameter int unsigned CLICK_WINDOW_CYCLES = 1000,
  parameter int unsigned MAX_CLICKS          = 3,
  parameter int unsigned FIFO_DEPTH          = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              key_pressed_stb_i,
  input  logic                              event_ready_i,
  output logic                              event_valid_o,
  output logic [$clog2(MAX_CLICKS+1)-1:0]   event_clicks_o,
  output logic                              busy_o
`ifdef KEY_CLICK_CLASSIFIER_DROP_CNT_EN
  ,
  output logic [7:0]                        drop_cnt_o
`endif
);

  localparam int unsigned CW = $clog2(MAX_CLICKS + 1);
  localparam int unsigned TW = $clog2(CLICK_WINDOW_CYCLES);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   click_cnt_q, click_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            busy_q, busy_d;

  logic            push;
  logic [CW-1:0]   push_val;

  logic [CW-1:0]   mem_q [FIFO_DEPTH];
  logic [CW-1:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            push_ok;

`ifdef KEY_CLICK_CLASSIFIER_DROP_CNT_EN
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            drop;
`endif

  // Click sequencing: a strobe beats a timeout in the same cycle.
  always_comb begin
    state_d     = state_q;
    click_cnt_d = click_cnt_q;
    timer_d     = timer_q;
    push        = 1'b0;
    push_val    = '0;
    unique case (state_q)
      IDLE: begin
        if (key_pressed_stb_i) begin
          if (MAX_CLICKS == 1) begin
            push     = 1'b1;
            push_val = CW'(1);
          end else begin
            state_d     = COUNT;
            click_cnt_d = CW'(1);
            timer_d     = '0;
          end
        end
      end
      COUNT: begin
        if (key_pressed_stb_i) begin
          if (click_cnt_q + CW'(1) == CW'(MAX_CLICKS)) begin
            push        = 1'b1;
            push_val    = CW'(MAX_CLICKS);
            state_d     = IDLE;
            click_cnt_d = '0;
            timer_d     = '0;
          end else begin
            click_cnt_d = click_cnt_q + CW'(1);
            timer_d     = '0;
          end
        end else if (timer_q == TW'(CLICK_WINDOW_CYCLES - 1)) begin
          push        = 1'b1;
          push_val    = click_cnt_q;
          state_d     = IDLE;
          click_cnt_d = '0;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        click_cnt_d = '0;
        timer_d     = '0;
      end
    endcase
    busy_d = (state_d == COUNT);
  end

  // FIFO status and handshake; a full FIFO still accepts a push when it pops.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !fifo_empty && event_ready_i;
    push_ok    = push && (!fifo_full || pop);
  end

  // FIFO storage and pointer update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_val;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

`ifdef KEY_CLICK_CLASSIFIER_DROP_CNT_EN
  // Saturating count of events lost to overflow.
  always_comb begin
    drop       = push && fifo_full && !pop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end
`endif

  // State register for sequencer, FIFO and drop counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      click_cnt_q <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
`ifdef KEY_CLICK_CLASSIFIER_DROP_CNT_EN
      drop_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      click_cnt_q <= click_cnt_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
`ifdef KEY_CLICK_CLASSIFIER_DROP_CNT_EN
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  // Outputs decode registered state only; the head reads as 0 when empty.
  always_comb begin
    event_valid_o  = !fifo_empty;
    event_clicks_o = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    busy_o         = busy_q;
`ifdef KEY_CLICK_CLASSIFIER_DROP_CNT_EN
    drop_cnt_o     = drop_cnt_q;
`endif
  end

endmodule

// File: tb/tb_key_click_classifier.sv
// Directed testbench for key_click_classifier (window 16, max 3 clicks, depth 4).
module tb_key_click_classifier;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb = 1'b0;
  logic       rdy = 1'b1;
  logic       valid;
  logic [1:0] clicks;
  logic       busy;
`ifdef KEY_CLICK_CLASSIFIER_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  key_click_classifier #(
    .CLICK_WINDOW_CYCLES(16),
    .MAX_CLICKS(3),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .key_pressed_stb_i(stb),
    .event_ready_i(rdy),
    .event_valid_o(valid),
    .event_clicks_o(clicks),
    .busy_o(busy)
`ifdef KEY_CLICK_CLASSIFIER_DROP_CNT_EN
    ,
    .drop_cnt_o(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Advance n active edges; inputs change and outputs are sampled 1 time unit later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle strobe sampled on the next edge.
  task automatic strobe();
    stb = 1'b1;
    tick(1);
    stb = 1'b0;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_drop(input string tag, input int exp);
`ifdef KEY_CLICK_CLASSIFIER_DROP_CNT_EN
    check(tag, int'(drop_cnt), exp);
`endif
  endtask

  initial begin
    // Reset
    tick(3);
    check("reset_valid", int'(valid), 0);
    check("reset_clicks", int'(clicks), 0);
    check("reset_busy", int'(busy), 0);
    check_drop("reset_drop", 0);
    rst = 1'b0;
    tick(2);

    // Single click: strobe at E, push at E+16
    strobe();
    check("single_busy_after_E", int'(busy), 1);
    tick(15);
    check("single_busy_E15", int'(busy), 1);
    check("single_valid_E15", int'(valid), 0);
    tick(1);
    check("single_valid_E16", int'(valid), 1);
    check("single_clicks", int'(clicks), 1);
    check("single_busy_E16", int'(busy), 0);
    tick(1);
    check("single_popped", int'(valid), 0);
    check("single_clicks_empty", int'(clicks), 0);

    // Double click, strobes 10 edges apart
    tick(3);
    strobe();
    tick(9);
    strobe();
    tick(15);
    check("double_a_busy", int'(busy), 1);
    check("double_a_valid_early", int'(valid), 0);
    tick(1);
    check("double_a_valid", int'(valid), 1);
    check("double_a_clicks", int'(clicks), 2);
    tick(1);

    // Double click with second strobe exactly on the window edge
    tick(3);
    strobe();
    tick(15);
    strobe();
    check("double_b_extend_busy", int'(busy), 1);
    check("double_b_extend_valid", int'(valid), 0);
    tick(15);
    check("double_b_valid_early", int'(valid), 0);
    tick(1);
    check("double_b_valid", int'(valid), 1);
    check("double_b_clicks", int'(clicks), 2);
    tick(1);

    // Triple click closes on the third strobe; next strobe opens new sequence
    tick(3);
    strobe();
    tick(1);
    strobe();
    tick(1);
    strobe();
    check("triple_valid", int'(valid), 1);
    check("triple_clicks", int'(clicks), 3);
    check("triple_busy", int'(busy), 0);
    strobe();
    check("triple_next_busy", int'(busy), 1);
    check("triple_next_popped", int'(valid), 0);
    tick(15);
    check("triple_next_valid_early", int'(valid), 0);
    tick(1);
    check("triple_next_valid", int'(valid), 1);
    check("triple_next_clicks", int'(clicks), 1);
    tick(1);

    // Overflow: ready low, five singles, fifth dropped
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(2);
      strobe();
      tick(16);
    end
    check("ovf_valid", int'(valid), 1);
    check("ovf_head", int'(clicks), 1);
    check_drop("ovf_drop", 1);
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("ovf_drain_valid", int'(valid), 1);
      check("ovf_drain_clicks", int'(clicks), 1);
      tick(1);
    end
    check("ovf_drain_empty", int'(valid), 0);

    // Full FIFO with pop on the push edge: push accepted
    rdy = 1'b0;
    strobe(); tick(16);                       // 1
    strobe(); strobe(); tick(16);             // 2
    strobe(); strobe(); strobe(); tick(2);    // 3
    strobe(); tick(16);                       // 1
    check("full_head", int'(clicks), 1);
    check_drop("full_drop_before", 1);
    strobe(); strobe(); tick(15);             // 2, pushed next edge
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0;
    check("full_pp_valid", int'(valid), 1);
    check("full_pp_head", int'(clicks), 2);
    check("full_pp_busy", int'(busy), 0);
    check_drop("full_pp_drop", 1);
    tick(2);
    check("full_pp_stable", int'(clicks), 2);
    rdy = 1'b1;
    check("full_drain0", int'(clicks), 3 - 1);
    tick(1);
    check("full_drain1", int'(clicks), 3);
    tick(1);
    check("full_drain2", int'(clicks), 1);
    tick(1);
    check("full_drain3", int'(clicks), 2);
    check("full_drain3_valid", int'(valid), 1);
    tick(1);
    check("full_drain_empty", int'(valid), 0);

    // Asynchronous reset mid-sequence discards the open sequence
    tick(3);
    strobe();
    tick(1);
    strobe();
    tick(2);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_clicks", int'(clicks), 0);
    check_drop("rst_drop", 0);
    tick(1);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check("rst_no_event", int'(valid), 0);
    end
    check("rst_idle_busy", int'(busy), 0);
    strobe();
    tick(15);
    check("rst_after_valid_early", int'(valid), 0);
    tick(1);
    check("rst_after_valid", int'(valid), 1);
    check("rst_after_clicks", int'(clicks), 1);
    tick(1);
    check("rst_after_popped", int'(valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
